// File: rtl/key_filter.sv
// key_filter: debounces a raw mechanical key into a clean level plus
// one-cycle press / release / long-press pulses.
//
// Optional build feature: define KEY_LONG_PRESS_EN to build the long-press
// counter. When it is undefined, long_flag is tied low and everything else
// is unchanged.
//
// Flow: key_in -> 2-flop synchroniser -> key_s -> key_p (1 = pressed)
//       -> IDLE / PRESS_FILT / DOWN / REL_FILT filter FSM -> registered outputs.
// state_dbg mirrors the FSM state register so checkers can bind to it.
module key_filter #(
  parameter logic [19:0] CNT_MAX        = 20'd999_999,
  parameter logic [25:0] LONG_MAX       = 26'd49_999_999,
  parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       key_level,
  output logic       key_flag,
  output logic       key_release_flag,
  output logic       long_flag,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] cnt;
  logic [19:0] cnt_nxt;
  logic        level_nxt;
  logic        key_flag_nxt;
  logic        rel_flag_nxt;

  logic        key_meta;
  logic        key_s;
  logic        key_p;

  // Two-flop synchroniser; both flops reset to the released input level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= KEY_ACTIVE_LOW;
      key_s    <= KEY_ACTIVE_LOW;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  // Pressed indication independent of key polarity.
  assign key_p = key_s ^ KEY_ACTIVE_LOW;

  // FSM state, filter counter, debounced level and press/release pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      cnt              <= 20'd0;
      key_level        <= 1'b0;
      key_flag         <= 1'b0;
      key_release_flag <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      key_level        <= level_nxt;
      key_flag         <= key_flag_nxt;
      key_release_flag <= rel_flag_nxt;
    end
  end

  // Next-state logic: a change of key_p must persist through CNT_MAX more
  // samples after the first one before it is accepted; any contrary sample
  // drops back to the settled state and clears the counter.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    level_nxt    = key_level;
    key_flag_nxt = 1'b0;
    rel_flag_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_p) begin
          state_nxt = PRESS_FILT;
          cnt_nxt   = 20'd1;
        end else begin
          cnt_nxt   = 20'd0;
        end
      end
      PRESS_FILT: begin
        if (!key_p) begin
          state_nxt = IDLE;
          cnt_nxt   = 20'd0;
        end else if (cnt >= CNT_MAX) begin
          state_nxt    = DOWN;
          cnt_nxt      = 20'd0;
          level_nxt    = 1'b1;
          key_flag_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      DOWN: begin
        if (!key_p) begin
          state_nxt = REL_FILT;
          cnt_nxt   = 20'd1;
        end else begin
          cnt_nxt   = 20'd0;
        end
      end
      REL_FILT: begin
        if (key_p) begin
          state_nxt = DOWN;
          cnt_nxt   = 20'd0;
        end else if (cnt >= CNT_MAX) begin
          state_nxt    = IDLE;
          cnt_nxt      = 20'd0;
          level_nxt    = 1'b0;
          rel_flag_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 20'd0;
        level_nxt = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

`ifdef KEY_LONG_PRESS_EN
  logic [25:0] long_cnt;

  // Long-press counter: restarts only on a fresh confirmed press, counts
  // while settled in DOWN, holds through release-filter bounces and
  // saturates at LONG_MAX so long_flag fires once per press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt  <= 26'd0;
      long_flag <= 1'b0;
    end else begin
      long_flag <= 1'b0;
      if (state == PRESS_FILT && state_nxt == DOWN) begin
        long_cnt <= 26'd0;
      end else if (state == DOWN && long_cnt < LONG_MAX) begin
        long_cnt <= long_cnt + 26'd1;
        if (long_cnt == LONG_MAX - 26'd1) begin
          long_flag <= 1'b1;
        end
      end
    end
  end
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter CNT_MAX, default 20'd999_999, number of consecutive stable cycles that confirm a press or release (20 ms at 50 MHz).
REQ-002 Parameter LONG_MAX, default 26'd49_999_999, number of held cycles in DOWN that confirm a long press (1 s at 50 MHz).
REQ-003 Parameter KEY_ACTIVE_LOW, default 1'b1; 1 = raw key reads 0 when pressed, 0 = raw key reads 1 when pressed.
REQ-004 sys_clk  input  1  single system clock, rising edge, 50 MHz nominal.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_in  input  1  raw mechanical key, asynchronous to sys_clk, bouncing.
REQ-007 key_level  output  1  debounced key state, 1 = pressed; feeds the downstream flip-flop/LED stage.
REQ-008 key_flag  output  1  one-cycle pulse on confirmed press.
REQ-009 key_release_flag  output  1  one-cycle pulse on confirmed release.
REQ-010 long_flag  output  1  one-cycle pulse on confirmed long press; port always present.

Function
REQ-011 key_in SHALL pass through a 2-flop synchroniser; only the second flop output (key_s) feeds logic; key_p = key_s XOR KEY_ACTIVE_LOW is the internal pressed indication.
REQ-012 FSM states SHALL be IDLE, PRESS_FILT, DOWN, REL_FILT, binary-encoded 2 bits.
REQ-013 IDLE: key_p=1 -> PRESS_FILT with cnt loaded to 1; otherwise stay, cnt=0.
REQ-014 PRESS_FILT: key_p=0 -> IDLE, cnt=0 (bounce rejected, no flag); key_p=1 and cnt=CNT_MAX -> DOWN; else cnt+1.
REQ-015 Transition PRESS_FILT->DOWN SHALL register key_flag=1 for exactly one cycle and key_level=1 on that same edge.
REQ-016 DOWN: key_p=0 -> REL_FILT with cnt loaded to 1; otherwise stay.
REQ-017 REL_FILT: key_p=1 -> DOWN, cnt=0, key_level stays 1; key_p=0 and cnt=CNT_MAX -> IDLE with key_level=0 and key_release_flag=1 for one cycle; else cnt+1.
REQ-018 cnt SHALL be 20 bits, saturate-free (cleared on every state change), never exceed CNT_MAX.
REQ-019 Latency: key_flag high on the edge CNT_MAX+2 cycles after the first sys_clk edge sampling a stable pressed key_in (2 sync + CNT_MAX filter).
REQ-020 key_flag, key_release_flag, long_flag SHALL never be high in the same cycle; each pulse is exactly one cycle wide.
REQ-021 Any glitch shorter than CNT_MAX cycles SHALL produce no flag and no key_level change.
REQ-022 key_level SHALL be glitch-free (registered output only).

Reset
REQ-023 sys_rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, long counter=0, key_level=0, all flags=0, both synchroniser flops to the released level (= KEY_ACTIVE_LOW).
REQ-024 Reset asserted mid-filter or mid-press SHALL abort without any flag; after release of reset a still-held key SHALL be re-qualified from IDLE (full CNT_MAX filter, then key_flag).

Configuration
REQ-025 Macro KEY_LONG_PRESS_EN defined: 26-bit long counter runs in DOWN, cleared on entry to DOWN from PRESS_FILT only; on reaching LONG_MAX long_flag pulses once per press; REL_FILT bounce back to DOWN SHALL not clear it.
REQ-026 Macro KEY_LONG_PRESS_EN undefined: long counter not built, long_flag tied 0; all other behaviour identical.

Verification (sim with CNT_MAX=4, LONG_MAX=20, 20 ns clock)
REQ-027 Reset 0 for 20 ns, key_in held 1 (released) -> all outputs 0, state IDLE throughout.
REQ-028 key_in=0 stable from t0 -> key_flag one pulse exactly 6 cycles after first sampling edge, key_level=1 same edge.
REQ-029 key_in bounces 0,1,0,1 with 2-cycle segments then settles 0 -> no flag during bounce; single key_flag 6 cycles after settling.
REQ-030 Held press then key_in=1 stable -> key_release_flag one pulse 6 cycles later, key_level=0 same edge; no second key_flag.
REQ-031 Press held 30 cycles, macro defined -> exactly one long_flag, 20 cycles after key_flag; macro undefined -> long_flag stays 0.
REQ-032 sys_rst_n pulsed low 1 cycle during DOWN with key still held -> key_level=0 immediately (async), then new key_flag 6 cycles after reset release.
